// File: rtl/ff_regfile_pkg.sv
// Shared definitions for the multi-ported flip-flop register file:
// address-width helper and the read-port index type.
package ff_regfile_pkg;

  // Address width for a given entry count; never narrower than one bit.
  function automatic int calc_aw(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  // Address width of the default 32-entry configuration.
  localparam int AW = calc_aw(32);

  // Index of each of the four read ports.
  typedef enum logic [1:0] {
    RP_11 = 2'd0,
    RP_12 = 2'd1,
    RP_21 = 2'd2,
    RP_22 = 2'd3
  } rd_port_e;

endpackage

// File: rtl/ff_regfile_rdport.sv
// One combinational read path of the register file.
// It decodes the address, applies the same-cycle write bypass, and produces rdy.
// rdy means the entry has no pending producer.
// A disabled or out-of-range read returns data 0 and rdy 0.
module ff_regfile_rdport
  import ff_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  parameter int AW         = 5
) (
  input  logic                           i_en,
  input  logic [AW-1:0]                  i_addr,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] i_mem_flat,
  input  logic [NUM_REGS-1:0]            i_busy,
  input  logic                           i_wr1_commit,
  input  logic [AW-1:0]                  i_wr1_addr,
  input  logic [DATA_WIDTH-1:0]          i_wr1_data,
  input  logic                           i_wr2_commit,
  input  logic [AW-1:0]                  i_wr2_addr,
  input  logic [DATA_WIDTH-1:0]          i_wr2_data,
  output logic [DATA_WIDTH-1:0]          o_data,
  output logic                           o_rdy
);

  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_sel_busy;
  logic                  w_in_range;
  logic                  w_is_zero;

  assign w_in_range = ({1'b0, i_addr} < NUM_REGS_W);
  assign w_is_zero  = (ZERO_REG != 0) && (i_addr == '0);

  // Select the stored entry and its busy bit for the requested address.
  always_comb begin
    w_sel_data = '0;
    w_sel_busy = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (i_addr == AW'(i)) begin
        w_sel_data = i_mem_flat[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_busy = i_busy[i];
      end
    end
  end

  // Output mux, highest priority first: disabled or out of range, then
  // hardwired zero entry, then bypass (port 1 before port 2), then storage.
  always_comb begin
    o_data = '0;
    o_rdy  = 1'b0;
    if (i_en && w_in_range) begin
      if (w_is_zero) begin
        o_data = '0;
        o_rdy  = 1'b1;
      end else if ((BYPASS != 0) && i_wr1_commit && (i_wr1_addr == i_addr)) begin
        o_data = i_wr1_data;
        o_rdy  = 1'b1;
      end else if ((BYPASS != 0) && i_wr2_commit && (i_wr2_addr == i_addr)) begin
        o_data = i_wr2_data;
        o_rdy  = 1'b1;
      end else begin
        o_data = w_sel_data;
        o_rdy  = !w_sel_busy;
      end
    end
  end

endmodule

// File: rtl/ff_regfile_mp.sv
// Register file with two write ports and four read ports, built from flip-flops.
// Each entry has a busy bit. An alloc sets it, which marks a pending producer.
// A committed write clears it.
// waw_err_o pulses for one cycle after a same-address dual write.
// busy_cnt_o tracks the number of busy entries.
module ff_regfile_mp
  import ff_regfile_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int AW        = calc_aw(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write1_en_i,
  input  logic                  write2_en_i,
  input  logic [AW-1:0]         write1_addr_i,
  input  logic [AW-1:0]         write2_addr_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  input  logic [DATA_WIDTH-1:0] data2_i,
  input  logic                  read11_en_i,
  input  logic                  read12_en_i,
  input  logic                  read21_en_i,
  input  logic                  read22_en_i,
  input  logic [AW-1:0]         read11_addr_i,
  input  logic [AW-1:0]         read12_addr_i,
  input  logic [AW-1:0]         read21_addr_i,
  input  logic [AW-1:0]         read22_addr_i,
  output logic [DATA_WIDTH-1:0] data11_o,
  output logic [DATA_WIDTH-1:0] data12_o,
  output logic [DATA_WIDTH-1:0] data21_o,
  output logic [DATA_WIDTH-1:0] data22_o,
  output logic                  rdy11_o,
  output logic                  rdy12_o,
  output logic                  rdy21_o,
  output logic                  rdy22_o,
  input  logic                  alloc_en_i,
  input  logic [AW-1:0]         alloc_addr_i,
  output logic                  waw_err_o,
  output logic [AW:0]           busy_cnt_o
);

  localparam logic [AW:0] NUM_REGS_W = (AW+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0]          r_mem [NUM_REGS];
  logic [NUM_REGS-1:0]            r_busy;
  logic                           r_waw_err;
  logic [AW:0]                    r_busy_cnt;

  logic                           w_wr1_commit;
  logic                           w_wr2_valid;
  logic                           w_wr2_commit;
  logic                           w_waw;
  logic                           w_alloc_valid;
  logic [NUM_REGS-1:0]            w_busy_nxt;
  logic [AW:0]                    w_cnt_nxt;
  logic [NUM_REGS*DATA_WIDTH-1:0] w_mem_flat;

  logic                           w_rd_en   [4];
  logic [AW-1:0]                  w_rd_addr [4];
  logic [DATA_WIDTH-1:0]          w_rd_data [4];
  logic                           w_rd_rdy  [4];

  // A write or alloc is only legal in range and, with ZERO_REG, off entry 0.
  // Reset suppresses all of them, so the bypass is also off during reset.
  assign w_wr1_commit = rst && write1_en_i
                      && ({1'b0, write1_addr_i} < NUM_REGS_W)
                      && !((ZERO_REG != 0) && (write1_addr_i == '0));
  assign w_wr2_valid  = rst && write2_en_i
                      && ({1'b0, write2_addr_i} < NUM_REGS_W)
                      && !((ZERO_REG != 0) && (write2_addr_i == '0));
  assign w_alloc_valid = rst && alloc_en_i
                       && ({1'b0, alloc_addr_i} < NUM_REGS_W)
                       && !((ZERO_REG != 0) && (alloc_addr_i == '0));

  // A same-address dual write keeps port 1 only and raises the error pulse.
  assign w_waw        = w_wr1_commit && w_wr2_valid && (write1_addr_i == write2_addr_i);
  assign w_wr2_commit = w_wr2_valid && !w_waw;

  // Next busy vector: writes clear, and an alloc applied last wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_wr1_commit && (write1_addr_i == AW'(i))) w_busy_nxt[i] = 1'b0;
      if (w_wr2_commit && (write2_addr_i == AW'(i))) w_busy_nxt[i] = 1'b0;
      if (w_alloc_valid && (alloc_addr_i == AW'(i))) w_busy_nxt[i] = 1'b1;
    end
  end

  // Population count of the next busy vector. It cannot exceed NUM_REGS, so it never wraps.
  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + (AW+1)'(w_busy_nxt[i]);
    end
  end

  // Storage, busy bits, the error pulse and the busy count, with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_waw_err  <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
      r_waw_err  <= w_waw;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr1_commit && (write1_addr_i == AW'(i))) begin
          r_mem[i] <= data1_i;
        end else if (w_wr2_commit && (write2_addr_i == AW'(i))) begin
          r_mem[i] <= data2_i;
        end
      end
    end
  end

  assign waw_err_o  = r_waw_err;
  assign busy_cnt_o = r_busy_cnt;

  // Flatten the storage so each read port can take it as one vector.
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign w_mem_flat[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
  end

  assign w_rd_en[RP_11]   = read11_en_i;
  assign w_rd_en[RP_12]   = read12_en_i;
  assign w_rd_en[RP_21]   = read21_en_i;
  assign w_rd_en[RP_22]   = read22_en_i;
  assign w_rd_addr[RP_11] = read11_addr_i;
  assign w_rd_addr[RP_12] = read12_addr_i;
  assign w_rd_addr[RP_21] = read21_addr_i;
  assign w_rd_addr[RP_22] = read22_addr_i;

  // Four identical read paths.
  for (genvar p = 0; p < 4; p++) begin : g_rd
    ff_regfile_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_REGS   (NUM_REGS),
      .BYPASS     (BYPASS),
      .ZERO_REG   (ZERO_REG),
      .AW         (AW)
    ) u_rdport (
      .i_en         (w_rd_en[p]),
      .i_addr       (w_rd_addr[p]),
      .i_mem_flat   (w_mem_flat),
      .i_busy       (r_busy),
      .i_wr1_commit (w_wr1_commit),
      .i_wr1_addr   (write1_addr_i),
      .i_wr1_data   (data1_i),
      .i_wr2_commit (w_wr2_commit),
      .i_wr2_addr   (write2_addr_i),
      .i_wr2_data   (data2_i),
      .o_data       (w_rd_data[p]),
      .o_rdy        (w_rd_rdy[p])
    );
  end

  assign data11_o = w_rd_data[RP_11];
  assign data12_o = w_rd_data[RP_12];
  assign data21_o = w_rd_data[RP_21];
  assign data22_o = w_rd_data[RP_22];
  assign rdy11_o  = w_rd_rdy[RP_11];
  assign rdy12_o  = w_rd_rdy[RP_12];
  assign rdy21_o  = w_rd_rdy[RP_21];
  assign rdy22_o  = w_rd_rdy[RP_22];

endmodule

// File: tb/tb_ff_regfile_mp.sv
// Bench for ff_regfile_mp with 24 entries, so that addresses 24..31 fall out of range.
module tb_ff_regfile_mp;

  localparam int DW = 32;
  localparam int NR = 24;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          write1_en_i, write2_en_i;
  logic [AW-1:0] write1_addr_i, write2_addr_i;
  logic [DW-1:0] data1_i, data2_i;
  logic          read11_en_i, read12_en_i, read21_en_i, read22_en_i;
  logic [AW-1:0] read11_addr_i, read12_addr_i, read21_addr_i, read22_addr_i;
  logic [DW-1:0] data11_o, data12_o, data21_o, data22_o;
  logic          rdy11_o, rdy12_o, rdy21_o, rdy22_o;
  logic          alloc_en_i;
  logic [AW-1:0] alloc_addr_i;
  logic          waw_err_o;
  logic [AW:0]   busy_cnt_o;

  int n_pass  = 0;
  int n_total = 0;

  ff_regfile_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .write1_en_i(write1_en_i), .write2_en_i(write2_en_i),
    .write1_addr_i(write1_addr_i), .write2_addr_i(write2_addr_i),
    .data1_i(data1_i), .data2_i(data2_i),
    .read11_en_i(read11_en_i), .read12_en_i(read12_en_i),
    .read21_en_i(read21_en_i), .read22_en_i(read22_en_i),
    .read11_addr_i(read11_addr_i), .read12_addr_i(read12_addr_i),
    .read21_addr_i(read21_addr_i), .read22_addr_i(read22_addr_i),
    .data11_o(data11_o), .data12_o(data12_o), .data21_o(data21_o), .data22_o(data22_o),
    .rdy11_o(rdy11_o), .rdy12_o(rdy12_o), .rdy21_o(rdy21_o), .rdy22_o(rdy22_o),
    .alloc_en_i(alloc_en_i), .alloc_addr_i(alloc_addr_i),
    .waw_err_o(waw_err_o), .busy_cnt_o(busy_cnt_o)
  );

  // Clock generation.
  always #5 clk = ~clk;

  typedef struct {
    logic          w1e; logic [AW-1:0] w1a; logic [DW-1:0] d1;
    logic          w2e; logic [AW-1:0] w2a; logic [DW-1:0] d2;
    logic          ae;  logic [AW-1:0] aa;
    int            rp;  logic re; logic [AW-1:0] ra;
    logic [DW-1:0] ed;  logic er;             // same-cycle read result
    logic [AW:0]   ec;  logic ew;             // registered outputs after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w1e, input int w1a, input logic [DW-1:0] d1,
                              input logic w2e, input int w2a, input logic [DW-1:0] d2,
                              input logic ae, input int aa,
                              input int rp, input logic re, input int ra,
                              input logic [DW-1:0] ed, input logic er,
                              input int ec, input logic ew);
    vec_t v;
    v.w1e = w1e; v.w1a = AW'(w1a); v.d1 = d1;
    v.w2e = w2e; v.w2a = AW'(w2a); v.d2 = d2;
    v.ae = ae; v.aa = AW'(aa);
    v.rp = rp; v.re = re; v.ra = AW'(ra);
    v.ed = ed; v.er = er; v.ec = (AW+1)'(ec); v.ew = ew;
    return v;
  endfunction

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", nm, act, exp);
  endtask

  task automatic drive_idle();
    write1_en_i = 0; write2_en_i = 0; write1_addr_i = '0; write2_addr_i = '0;
    data1_i = '0; data2_i = '0; alloc_en_i = 0; alloc_addr_i = '0;
    read11_en_i = 0; read12_en_i = 0; read21_en_i = 0; read22_en_i = 0;
    read11_addr_i = '0; read12_addr_i = '0; read21_addr_i = '0; read22_addr_i = '0;
  endtask

  task automatic set_read(input int rp, input logic en, input logic [AW-1:0] a);
    case (rp)
      0: begin read11_en_i = en; read11_addr_i = a; end
      1: begin read12_en_i = en; read12_addr_i = a; end
      2: begin read21_en_i = en; read21_addr_i = a; end
      default: begin read22_en_i = en; read22_addr_i = a; end
    endcase
  endtask

  function automatic logic [DW:0] get_read(input int rp);
    case (rp)
      0: return {rdy11_o, data11_o};
      1: return {rdy12_o, data12_o};
      2: return {rdy21_o, data21_o};
      default: return {rdy22_o, data22_o};
    endcase
  endfunction

  task automatic check_read(input string nm, input int rp, input logic [DW-1:0] ed, input logic er);
    logic [DW:0] r;
    r = get_read(rp);
    check({nm, "_data"}, r[DW-1:0], ed);
    check({nm, "_rdy"}, {31'd0, r[DW]}, {31'd0, er});
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    logic [DW:0] other;
    @(negedge clk);
    drive_idle();
    write1_en_i = v.w1e; write1_addr_i = v.w1a; data1_i = v.d1;
    write2_en_i = v.w2e; write2_addr_i = v.w2a; data2_i = v.d2;
    alloc_en_i  = v.ae;  alloc_addr_i  = v.aa;
    set_read(v.rp, v.re, v.ra);
    #1;
    check_read($sformatf("v%0d", idx), v.rp, v.ed, v.er);
    other = get_read((v.rp + 1) % 4);
    check($sformatf("v%0d_idle_port", idx), other[DW-1:0] | {31'd0, other[DW]}, '0);
    @(posedge clk); #1;
    check($sformatf("v%0d_busy_cnt", idx), {26'd0, busy_cnt_o}, {26'd0, v.ec});
    check($sformatf("v%0d_waw", idx), {31'd0, waw_err_o}, {31'd0, v.ew});
  endtask

  // Stimulus.
  initial begin
    //            w1e w1a d1            w2e w2a d2       ae aa  rp re ra  ed            er ec ew
    vecs.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0,  0, 1, 5,  32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  0, 1, 5,  32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mk(1, 7, 32'h1111,     1, 7, 32'h2222, 0, 0, 1, 1, 7,  32'h1111,     1, 0, 1));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  1, 1, 7,  32'h1111,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 3, 32'hA5A5, 0, 0, 3, 1, 3,  32'hA5A5,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  2, 1, 3,  32'hA5A5,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 9,  0, 1, 9,  32'h0,        1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  0, 1, 9,  32'h0,        0, 1, 0));
    vecs.push_back(mk(1, 9, 32'h99,       0, 0, 0,       0, 0,  1, 1, 9,  32'h99,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  1, 1, 9,  32'h99,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            1, 9, 32'h1234, 1, 9, 2, 1, 9,  32'h1234,     1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  2, 1, 9,  32'h1234,     0, 1, 0));
    vecs.push_back(mk(1, 9, 32'h55,       0, 0, 0,       1, 10, 3, 1, 10, 32'h0,        1, 1, 0));
    vecs.push_back(mk(1, 10, 32'hAA,      0, 0, 0,       1, 11, 0, 1, 9,  32'h55,       1, 1, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       1, 12, 0, 1, 11, 32'h0,        0, 2, 0));
    vecs.push_back(mk(1, 11, 32'h11,      1, 12, 32'h12, 0, 0,  3, 1, 12, 32'h12,       1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  2, 1, 11, 32'h11,       1, 0, 0));
    vecs.push_back(mk(1, 0, 32'hFFFF,     0, 0, 0,       1, 0,  0, 1, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  0, 1, 0,  32'h0,        1, 0, 0));
    vecs.push_back(mk(1, 30, 32'hBAD,     0, 0, 0,       1, 30, 1, 1, 30, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 23, 32'h2323,    0, 0, 0,       0, 0,  1, 1, 23, 32'h2323,     1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  2, 0, 5,  32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  3, 1, 5,  32'hDEADBEEF, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0,            0, 0, 0,       0, 0,  3, 1, 23, 32'h2323,     1, 0, 0));

    // Reset state.
    rst = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    check("reset_busy_cnt", {26'd0, busy_cnt_o}, '0);
    check("reset_waw", {31'd0, waw_err_o}, '0);
    set_read(0, 1, 5);
    #1;
    check_read("reset_rd5", 0, 32'h0, 1);

    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], i);

    // Reset mid-operation: first allocate two entries.
    @(negedge clk); drive_idle(); alloc_en_i = 1; alloc_addr_i = 5'd4;
    @(negedge clk); alloc_addr_i = 5'd6;
    @(posedge clk); #1;
    check("pre_rst_busy_cnt", {26'd0, busy_cnt_o}, 32'd2);
    // During reset, drive a same-address dual write and an alloc. All of them are discarded.
    @(negedge clk); drive_idle(); rst = 1'b0;
    write1_en_i = 1; write1_addr_i = 5'd7; data1_i = 32'h1;
    write2_en_i = 1; write2_addr_i = 5'd7; data2_i = 32'h2;
    alloc_en_i = 1; alloc_addr_i = 5'd8;
    @(posedge clk); #1;
    check("rst_busy_cnt", {26'd0, busy_cnt_o}, '0);
    check("rst_waw", {31'd0, waw_err_o}, '0);
    @(negedge clk); drive_idle(); rst = 1'b1;
    set_read(0, 1, 5); set_read(1, 1, 4); set_read(2, 1, 8); set_read(3, 1, 7);
    #1;
    check_read("post_rst_rd5", 0, 32'h0, 1);
    check_read("post_rst_rd4", 1, 32'h0, 1);
    check_read("post_rst_rd8", 2, 32'h0, 1);
    check_read("post_rst_rd7", 3, 32'h0, 1);
    @(posedge clk); #1;
    check("post_rst_waw", {31'd0, waw_err_o}, '0);
    check("post_rst_busy_cnt", {26'd0, busy_cnt_o}, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ff_regfile_mp.md
FF_REGFILE_MP -- requirements
Module: ff_regfile_mp

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the entry width in bits.
REQ-002 Parameter NUM_REGS, default 32, is the entry count (>=2).
REQ-003 Parameter BYPASS, default 1, enables write-to-read forwarding when set to 1.
REQ-004 Parameter ZERO_REG, default 1, hardwires entry 0 to zero when set to 1.
REQ-005 Port clk, input, 1, is the single clock; all state updates on posedge.
REQ-006 Port rst, input, 1, is the reset: synchronous, active-low.
REQ-007 Ports write1_en_i, write2_en_i, input, 1 each, are the write enables.
REQ-008 Ports write1_addr_i, write2_addr_i, input, AW each, are the write addresses.
REQ-009 Ports data1_i, data2_i, input, DATA_WIDTH each, are the write data.
REQ-010 Ports read11_en_i, read12_en_i, read21_en_i, read22_en_i, input, 1 each, are the read enables.
REQ-011 Ports read11_addr_i, read12_addr_i, read21_addr_i, read22_addr_i, input, AW each, are the read addresses.
REQ-012 Ports data11_o, data12_o, data21_o, data22_o, output, DATA_WIDTH each, are the read data.
REQ-013 Ports rdy11_o, rdy12_o, rdy21_o, rdy22_o, output, 1 each, indicate the read entry is not busy.
REQ-014 Port alloc_en_i, input, 1, marks an entry busy (pending producer).
REQ-015 Port alloc_addr_i, input, AW, is the entry to mark busy.
REQ-016 Port waw_err_o, output, 1, is a registered pulse flagging a same-address dual write.
REQ-017 Port busy_cnt_o, output, AW+1, is the registered count of busy entries.

Function
REQ-018 Writes SHALL be synchronous; distinct-address simultaneous writes both commit.
REQ-019 Same-address simultaneous writes SHALL commit data1_i only, and waw_err_o SHALL be 1 for exactly the following cycle.
REQ-020 Reads SHALL be combinational; en=0 yields data=0 and rdy=0.
REQ-021 With BYPASS=1, a read of an address written this cycle SHALL return the write data (port 1 priority) with rdy=1.
REQ-022 With BYPASS=0, a read SHALL return the stored value and the current busy state.
REQ-023 Any address >= NUM_REGS SHALL be ignored on writes and allocs; reads of it SHALL return data 0, rdy 0.
REQ-024 With ZERO_REG=1, writes/allocs to entry 0 SHALL be ignored; reads of entry 0 SHALL return data 0, rdy 1.
REQ-025 alloc_en_i SHALL set busy[alloc_addr_i] at the next edge; any committed write SHALL clear busy of its address.
REQ-026 When an alloc and a write target the same address in one cycle, alloc SHALL win (busy=1, data still written).
REQ-027 A read's rdy SHALL be the inverse of busy, except when overridden by REQ-021.
REQ-028 busy_cnt_o SHALL equal the population count of busy bits after each edge (net +1/0/-1/-2 per cycle; never wraps).

Reset
REQ-029 While rst=0 at a posedge, all entries, busy bits, waw_err_o and busy_cnt_o SHALL be cleared to 0; all write/alloc inputs are ignored.
REQ-030 Reset asserted mid-operation SHALL discard same-cycle writes and allocs; read outputs then reflect cleared state combinationally.

Structure
REQ-031 Package ff_regfile_pkg SHALL hold the AW = $clog2(NUM_REGS) function/localparam and the read-port index typedef.
REQ-032 The four identical read paths SHALL be instances of one sub-module, ff_regfile_rdport (address decode, bypass mux, rdy generation).

Verification
REQ-033 After reset, write1 addr 5 = 0xDEADBEEF; the next cycle, read11 addr 5 -> data11_o=0xDEADBEEF, rdy11_o=1.
REQ-034 write1 and write2 both target addr 7 (0x1111 / 0x2222) -> entry 7 = 0x1111; waw_err_o=1 for one cycle, then 0.
REQ-035 BYPASS=1: write2 addr 3 = 0xA5A5 while read22 addr 3 in the same cycle -> data22_o=0xA5A5, rdy22_o=1.
REQ-036 Alloc addr 9 -> rdy=0 and busy_cnt_o=1; a later write addr 9 -> rdy=1 and busy_cnt_o=0; alloc+write on addr 9 in one cycle -> busy stays 1.
REQ-037 ZERO_REG=1: write addr 0 = 0xFFFF -> read addr 0 returns 0, rdy 1; pulse rst=0 after filling entries -> all reads 0, busy_cnt_o=0.
